// File: rtl/drum_audio_out.sv
// drum_audio_out: converts solver center-node amplitude to 16-bit PCM,
// buffers it in a small FIFO and paces the solver by the codec rate.
module drum_audio_out #(
    parameter int DEPTH      = 8,
    parameter int CW         = 4,
    parameter int GAIN_SHIFT = 0
) (
    input  logic          clk_50,
    input  logic          reset,
    input  logic [17:0]   sample_in,
    input  logic          sample_valid,
    output logic          step_enable,
    output logic [15:0]   audio_data,
    output logic          audio_valid,
    input  logic          audio_ready,
    output logic [CW-1:0] fifo_count,
    output logic          overflow_sticky,
    output logic [31:0]   sample_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = 18 + GAIN_SHIFT;
    localparam logic signed [WW-1:0] SAT_MAX = WW'(131071);
    localparam logic signed [WW-1:0] SAT_MIN = WW'(-131072);

    logic signed [17:0]   w_in;
    logic signed [WW-1:0] w_wide;
    logic [17:0]          w_sat;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic [CW:0]          w_occ;

    logic [15:0]          r_conv_data;
    logic                 r_conv_valid;
    logic [15:0]          r_mem [DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic [31:0]          r_scount;

    assign w_in   = sample_in;
    assign w_wide = WW'(w_in) <<< GAIN_SHIFT;

    // Clamp the gained sample back into the 1.17 range
    always_comb begin
        w_sat = w_wide[17:0];
        if (w_wide > SAT_MAX) begin
            w_sat = 18'h1FFFF;
        end else if (w_wide < SAT_MIN) begin
            w_sat = 18'h20000;
        end
    end

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = audio_valid && audio_ready;
    assign w_push = r_conv_valid && (!w_full || w_pop);
    assign w_occ  = (CW+1)'(r_count) + (CW+1)'(r_conv_valid);

    assign step_enable     = (w_occ < (CW+1)'(DEPTH));
    assign audio_valid     = (r_count != '0);
    assign audio_data      = audio_valid ? r_mem[r_rd] : 16'h0000;
    assign fifo_count      = r_count;
    assign overflow_sticky = r_ovf;
    assign sample_count    = r_scount;

    // Conversion stage: dropping two LSBs floors toward negative infinity
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_conv_valid <= 1'b0;
            r_conv_data  <= 16'h0000;
        end else begin
            r_conv_valid <= sample_valid;
            if (sample_valid) begin
                r_conv_data <= w_sat[17:2];
            end
        end
    end

    // FIFO storage; contents are masked by audio_valid so need no reset
    always_ff @(posedge clk_50) begin
        if (w_push) begin
            r_mem[r_wr] <= r_conv_data;
        end
    end

    // Pointers, occupancy, drop flag and handshake counter
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_scount <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd     <= r_rd + 1'b1;
                r_scount <= r_scount + 32'd1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_conv_valid && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drum_audio_out.sv
// tb_drum_audio_out: directed checks of conversion, saturation, FIFO
// fill/drop, full push+pop, async reset and randomized back-pressure.
module tb_drum_audio_out;

    logic        clk_50;
    logic        reset;
    logic [17:0] sample_in;
    logic        sample_valid;
    logic        audio_ready;

    logic        step_enable;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic [3:0]  fifo_count;
    logic        overflow_sticky;
    logic [31:0] sample_count;

    logic        g2_step_enable;
    logic [15:0] g2_audio_data;
    logic        g2_audio_valid;
    logic [3:0]  g2_fifo_count;
    logic        g2_overflow_sticky;
    logic [31:0] g2_sample_count;

    int errors = 0;
    int checks = 0;

    drum_audio_out #(.DEPTH(8), .CW(4), .GAIN_SHIFT(0)) u_dut (
        .clk_50          (clk_50),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .step_enable     (step_enable),
        .audio_data      (audio_data),
        .audio_valid     (audio_valid),
        .audio_ready     (audio_ready),
        .fifo_count      (fifo_count),
        .overflow_sticky (overflow_sticky),
        .sample_count    (sample_count)
    );

    drum_audio_out #(.DEPTH(8), .CW(4), .GAIN_SHIFT(2)) u_dut_g2 (
        .clk_50          (clk_50),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .step_enable     (g2_step_enable),
        .audio_data      (g2_audio_data),
        .audio_valid     (g2_audio_valid),
        .audio_ready     (audio_ready),
        .fifo_count      (g2_fifo_count),
        .overflow_sticky (g2_overflow_sticky),
        .sample_count    (g2_sample_count)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // one strobe, check latency, check head, let ready=1 pop it
    task automatic conv(input string tag, input logic [17:0] v,
                        input logic [15:0] exp, input bit use_g2);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk({tag, "_lat"}, use_g2 ? g2_audio_valid : audio_valid, 0);
        tick();
        chk({tag, "_vld"}, use_g2 ? g2_audio_valid : audio_valid, 1);
        chk({tag, "_dat"}, use_g2 ? g2_audio_data : audio_data, exp);
        tick();
    endtask

    task automatic fill8(input bit extra);
        for (int i = 1; i <= 8; i++) begin
            sample_in    = 18'(i << 2);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        tick();
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] prev_data;
    logic        prev_stall;
    int          sent;
    int          got;
    int          cyc;
    logic [15:0] d;

    initial begin
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        audio_ready  = 1'b1;
        tick();
        tick();
        chk("rst_valid", audio_valid, 0);
        chk("rst_data", audio_data, 16'h0000);
        chk("rst_count", fifo_count, 0);
        chk("rst_step", step_enable, 1);
        chk("rst_ovf", overflow_sticky, 0);
        chk("rst_scnt", sample_count, 0);
        reset = 1'b0;
        tick();

        conv("c_quarter", 18'h08000, 16'h2000, 1'b0);
        conv("c_mhalf", 18'h30000, 16'hC000, 1'b0);
        conv("c_m1lsb", 18'h3FFFF, 16'hFFFF, 1'b0);
        chk("c_scnt", sample_count, 3);
        chk("c_empty", fifo_count, 0);

        conv("s_pos", 18'h08000, 16'h7FFF, 1'b1);
        conv("s_neg", 18'h37000, 16'h8000, 1'b1);
        conv("s_mid", 18'h01000, 16'h1000, 1'b1);

        audio_ready = 1'b0;
        fill8(1'b0);
        chk("f_count", fifo_count, 8);
        chk("f_step", step_enable, 0);
        chk("f_ovf0", overflow_sticky, 0);
        chk("f_head", audio_data, 16'h0001);
        sample_in    = 18'(9 << 2);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("d_ovf", overflow_sticky, 1);
        chk("d_count", fifo_count, 8);
        chk("d_head", audio_data, 16'h0001);

        do_reset();
        chk("r2_ovf", overflow_sticky, 0);
        fill8(1'b0);
        sample_in    = 18'(10 << 2);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        audio_ready  = 1'b1;
        chk("pp_step", step_enable, 0);
        tick();
        audio_ready = 1'b0;
        chk("pp_count", fifo_count, 8);
        chk("pp_ovf", overflow_sticky, 0);
        chk("pp_scnt", sample_count, 1);
        chk("pp_head", audio_data, 16'h0002);

        do_reset();
        for (int i = 1; i <= 3; i++) begin
            sample_in    = 18'(i << 2);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        tick();
        chk("ar_pre", fifo_count, 3);
        #5;
        reset = 1'b1;
        #1;
        chk("ar_valid", audio_valid, 0);
        chk("ar_count", fifo_count, 0);
        chk("ar_scnt", sample_count, 0);
        chk("ar_ovf", overflow_sticky, 0);
        chk("ar_step", step_enable, 1);
        chk("ar_data", audio_data, 16'h0000);
        tick();
        reset = 1'b0;
        tick();

        sent       = 0;
        got        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (got < 20 && cyc < 2000) begin
            if (prev_stall) begin
                chk("bp_hold_v", audio_valid, 1);
                chk("bp_hold_d", audio_data, prev_data);
            end
            sample_valid = 1'b0;
            if (sent < 20 && step_enable && $urandom_range(0, 3) != 0) begin
                d            = 16'(sent * 16'h1357 + 16'h0A5);
                sample_in    = {d, 2'b00};
                sample_valid = 1'b1;
                exp_q.push_back(d);
                sent++;
            end
            audio_ready = ($urandom_range(0, 2) == 0);
            if (audio_valid && audio_ready) begin
                if (exp_q.size() == 0) begin
                    chk("bp_spurious", 1, 0);
                end else begin
                    chk("bp_order", audio_data, exp_q.pop_front());
                end
                got++;
            end
            prev_stall = audio_valid && !audio_ready;
            prev_data  = audio_data;
            tick();
            cyc++;
        end
        sample_valid = 1'b0;
        audio_ready  = 1'b0;
        chk("bp_timeout", cyc < 2000, 1);
        chk("bp_scnt", sample_count, 20);
        chk("bp_ovf", overflow_sticky, 0);
        chk("bp_empty", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drum_audio_out.md
Name: drum_audio_out

Overview:
- Downstream stage of the drum-grid solver. Once per completed grid time step it takes the center-node amplitude (18-bit signed 1.17).
- Applies a power-of-two gain with saturation and converts the result to 16-bit signed PCM.
- Buffers samples in a small register FIFO and presents them on a valid/ready stream to the audio-codec bus master.
- Drives step_enable back to the solver, so the simulation rate is paced by the codec sample rate.

Parameters:
- DEPTH, 8: FIFO entries. Power of two, 2..32.
- CW, 4: width of fifo_count. Must equal log2(DEPTH)+1.
- GAIN_SHIFT, 0: left shift applied to the sample before saturation. Range 0..7.

Ports:
- clk_50 in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- sample_in in 18: signed 1.17 center-node amplitude.
- sample_valid in 1: one-cycle strobe, one per completed grid time step.
- step_enable out 1: high means the solver may begin the next time step.
- audio_data out 16: signed PCM, head of FIFO.
- audio_valid out 1: audio_data holds a valid sample.
- audio_ready in 1: codec side accepts a sample this cycle.
- fifo_count out CW: number of entries currently in the FIFO.
- overflow_sticky out 1: a sample was dropped since reset.
- sample_count out 32: number of completed output handshakes.

Behaviour:
- Reset:
  - Clock is clk_50. reset is asynchronous, active-high.
  - While reset is high: all FIFO pointers, fifo_count, the conversion stage, overflow_sticky and sample_count are 0; audio_valid=0; audio_data=0; step_enable=1.
  - Reset asserted mid-operation discards all buffered and in-flight samples immediately, without waiting for a clock edge.
- Stage 1, conversion register (conv_data, conv_valid):
  - conv_valid <= sample_valid on every edge.
  - When sample_valid=1: wide = sign-extended sample_in <<< GAIN_SHIFT, width 18+GAIN_SHIFT.
  - If wide > 131071, sat = 18'h1FFFF. If wide < -131072, sat = 18'h20000. Otherwise sat = wide[17:0].
  - conv_data <= sat[17:2], truncated toward negative infinity.
- Stage 2, FIFO:
  - pop = audio_valid && audio_ready.
  - push = conv_valid && (fifo_count < DEPTH || pop).
  - A push writes mem[wr_ptr] and advances wr_ptr. A pop advances rd_ptr. Pointers wrap modulo DEPTH.
  - fifo_count: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
- Drop:
  - If conv_valid=1 and fifo_count==DEPTH and pop=0, the sample is dropped and overflow_sticky <= 1.
  - overflow_sticky clears only on reset.
- Output:
  - audio_valid = (fifo_count != 0).
  - audio_data = mem[rd_ptr] when audio_valid=1, else 16'h0000. Combinational from registers.
  - While audio_valid=1 and audio_ready=0, audio_data and audio_valid hold stable.
  - audio_ready while audio_valid=0 has no effect.
- sample_count increments on each pop. It wraps at 2^32.
- Latency: sample_valid sampled at edge N causes audio_valid to go high after edge N+1, when the FIFO was empty.
- step_enable = ((fifo_count + conv_valid) < DEPTH), combinational.
  - The solver must not issue sample_valid while step_enable=0.
  - If it does, the drop rule above applies.
- sample_valid asserted on consecutive cycles is legal. Each strobe is one sample.

Test Plan:
- Reset: assert reset mid-cycle with 3 samples buffered -> audio_valid=0, fifo_count=0, sample_count=0, overflow_sticky=0, step_enable=1, all without waiting for a clock edge.
- Conversion, GAIN_SHIFT=0, audio_ready=1: sample_in 18'h08000 (0.25) -> audio_data 16'h2000; sample_in 18'h30000 (-0.5) -> 16'hC000; sample_in 18'h3FFFF -> 16'hFFFF. Each has audio_valid two edges after the strobe.
- Saturation, GAIN_SHIFT=2: 18'h08000 -> 16'h7FFF; 18'h37000 -> 16'h8000; 18'h01000 -> 16'h1000.
- Fill, DEPTH=8, audio_ready=0: 8 strobes with values 1..8 (<<2) -> fifo_count=8, step_enable=0. A 9th strobe -> dropped, overflow_sticky=1, fifo_count=8, head unchanged.
- Full with simultaneous push/pop: fifo_count=8, conv_valid=1, audio_ready=1 in the same cycle -> push accepted, fifo_count stays 8, overflow_sticky stays 0, sample_count +1.
- Back-pressure: 20 samples with audio_ready randomly toggled -> output order identical to input order, audio_data stable whenever valid&&!ready, sample_count=20 at end, no drops when the solver obeys step_enable.
